// File: rtl/duty_meter_pkg.sv
// Shared types and constants for the duty-cycle meter and its percentage divider.
package duty_meter_pkg;

    localparam int PCT_W     = 7;
    localparam int DIV_STEPS = 7;
    localparam int PCT_SCALE = 100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        DIVIDE  = 2'd3
    } state_e;

endpackage

// File: rtl/pct_divider.sv
// Sequential restoring divider: quotient = floor(dividend_hi * 100 / divisor),
// one quotient bit per clock, MSB first. The final bit is presented combinationally with done.
module pct_divider
    import duty_meter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] dividend_hi,
    input  logic [CNT_W-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [PCT_W-1:0] quotient
);

    localparam int DVD_W  = CNT_W + PCT_W;
    localparam int STEP_W = $clog2(DIV_STEPS + 1);
    localparam logic [DVD_W-1:0]  SCALE     = DVD_W'(PCT_SCALE);
    localparam logic [STEP_W-1:0] STEP_LOAD = STEP_W'(DIV_STEPS);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(1);

    logic [CNT_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  dvs_q, dvs_d;
    logic [PCT_W-1:0]  lo_q, lo_d;
    logic [PCT_W-2:0]  quo_q, quo_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [DVD_W-1:0]  dividend;
    logic [CNT_W:0]    trial;
    logic              qbit;

    always_comb begin
        dividend = {{PCT_W{1'b0}}, dividend_hi} * SCALE;
        trial    = {rem_q, lo_q[PCT_W-1]};
        qbit     = (trial >= {1'b0, dvs_q});

        rem_d  = rem_q;
        dvs_d  = dvs_q;
        lo_d   = lo_q;
        quo_d  = quo_q;
        step_d = step_q;

        if (abort) begin
            step_d = '0;
        end else if (start) begin
            // hi <= per keeps the quotient below 2^PCT_W, so the upper dividend bits
            // are already smaller than the divisor and can seed the remainder directly.
            rem_d  = dividend[DVD_W-1:PCT_W];
            lo_d   = dividend[PCT_W-1:0];
            dvs_d  = divisor;
            quo_d  = '0;
            step_d = STEP_LOAD;
        end else if (step_q != '0) begin
            rem_d  = qbit ? (trial[CNT_W-1:0] - dvs_q) : trial[CNT_W-1:0];
            lo_d   = {lo_q[PCT_W-2:0], 1'b0};
            quo_d  = {quo_q[PCT_W-3:0], qbit};
            step_d = step_q - STEP_LAST;
        end

        busy     = (step_q != '0);
        done     = (step_q == STEP_LAST) && !abort && !start;
        quotient = {quo_q, qbit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q  <= '0;
            dvs_q  <= '0;
            lo_q   <= '0;
            quo_q  <= '0;
            step_q <= '0;
        end else begin
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            lo_q   <= lo_d;
            quo_q  <= quo_d;
            step_q <= step_d;
        end
    end

endmodule

// File: rtl/duty_cycle_meter.sv
// Duty-cycle meter: measures high time and period of sig_in in clk cycles, rising edge to
// rising edge, and reports floor(high*100/period) after a 7-cycle background division.
//
// state   | meaning
// IDLE    | disabled, results held
// ARM     | waiting for a rising edge to open the first period
// MEASURE | counting the current period
// DIVIDE  | dividing the previous period while counting the next one
module duty_cycle_meter
    import duty_meter_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [PCT_W-1:0] duty_pct,
    output logic             valid,
    output logic             overflow,
    output logic             missed
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic             rise;
    logic [CNT_W-1:0] per_ctr_q, per_ctr_d, hi_ctr_q, hi_ctr_d;
    logic [CNT_W-1:0] per_inc, hi_inc;
    logic [CNT_W-1:0] snap_per_q, snap_per_d, snap_hi_q, snap_hi_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d, period_cnt_q, period_cnt_d;
    logic [PCT_W-1:0] duty_pct_q, duty_pct_d;
    logic             valid_q, valid_d;
    logic             overflow_q, overflow_d;
    logic             missed_q, missed_d;
    logic             div_miss_q, div_miss_d;
    logic             div_start, div_abort, div_busy, div_done;
    logic [PCT_W-1:0] div_quot;

    pct_divider #(
        .CNT_W (CNT_W)
    ) u_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (div_start),
        .abort       (div_abort),
        .dividend_hi (hi_ctr_q),
        .divisor     (per_ctr_q),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (div_quot)
    );

    always_comb begin
        rise      = s2_q & ~s3_q;
        per_inc   = per_ctr_q + CNT_ONE;
        hi_inc    = hi_ctr_q + CNT_W'(s2_q);
        div_abort = ~enable;

        state_d      = state_q;
        per_ctr_d    = per_ctr_q;
        hi_ctr_d     = hi_ctr_q;
        snap_per_d   = snap_per_q;
        snap_hi_d    = snap_hi_q;
        high_cnt_d   = high_cnt_q;
        period_cnt_d = period_cnt_q;
        duty_pct_d   = duty_pct_q;
        valid_d      = 1'b0;
        overflow_d   = overflow_q;
        missed_d     = missed_q;
        div_miss_d   = div_miss_q;
        div_start    = 1'b0;

        if (!enable) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = ARM;
                ARM: begin
                    if (rise) begin
                        per_ctr_d = CNT_ONE;
                        hi_ctr_d  = CNT_ONE;
                        state_d   = MEASURE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        snap_per_d = per_ctr_q;
                        snap_hi_d  = hi_ctr_q;
                        per_ctr_d  = CNT_ONE;
                        hi_ctr_d   = CNT_ONE;
                        div_start  = 1'b1;
                        div_miss_d = 1'b0;
                        state_d    = DIVIDE;
                    end else if (per_inc == CNT_MAX) begin
                        per_ctr_d  = CNT_MAX;
                        overflow_d = 1'b1;
                        state_d    = ARM;
                    end else begin
                        per_ctr_d = per_inc;
                        hi_ctr_d  = hi_inc;
                    end
                end
                DIVIDE: begin
                    if (rise) begin
                        per_ctr_d  = CNT_ONE;
                        hi_ctr_d   = CNT_ONE;
                        missed_d   = 1'b1;
                        div_miss_d = 1'b1;
                    end else begin
                        per_ctr_d = per_inc;
                        hi_ctr_d  = hi_inc;
                    end
                    // A period dropped during this division keeps missed set past its own valid.
                    if (div_done) begin
                        high_cnt_d   = snap_hi_q;
                        period_cnt_d = snap_per_q;
                        duty_pct_d   = div_quot;
                        valid_d      = 1'b1;
                        overflow_d   = 1'b0;
                        if (!div_miss_q && !rise) begin
                            missed_d = 1'b0;
                        end
                        state_d = MEASURE;
                    end else if (!div_busy) begin
                        state_d = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s1_q         <= 1'b0;
            s2_q         <= 1'b0;
            s3_q         <= 1'b0;
            per_ctr_q    <= '0;
            hi_ctr_q     <= '0;
            snap_per_q   <= '0;
            snap_hi_q    <= '0;
            high_cnt_q   <= '0;
            period_cnt_q <= '0;
            duty_pct_q   <= '0;
            valid_q      <= 1'b0;
            overflow_q   <= 1'b0;
            missed_q     <= 1'b0;
            div_miss_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            s1_q         <= sig_in;
            s2_q         <= s1_q;
            s3_q         <= s2_q;
            per_ctr_q    <= per_ctr_d;
            hi_ctr_q     <= hi_ctr_d;
            snap_per_q   <= snap_per_d;
            snap_hi_q    <= snap_hi_d;
            high_cnt_q   <= high_cnt_d;
            period_cnt_q <= period_cnt_d;
            duty_pct_q   <= duty_pct_d;
            valid_q      <= valid_d;
            overflow_q   <= overflow_d;
            missed_q     <= missed_d;
            div_miss_q   <= div_miss_d;
        end
    end

    assign high_cnt   = high_cnt_q;
    assign period_cnt = period_cnt_q;
    assign duty_pct   = duty_pct_q;
    assign valid      = valid_q;
    assign overflow   = overflow_q;
    assign missed     = missed_q;

endmodule

// File: tb/tb_duty_cycle_meter.sv
// Bench for duty_cycle_meter: table-driven steady waveforms, directed corner sequences,
// and a randomized pulse train checked against a period-level reference model.
module tb_duty_cycle_meter;
    import duty_meter_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, enable, sig_in;
    logic [15:0] high_cnt, period_cnt;
    logic [6:0]  duty_pct;
    logic        valid, overflow, missed;

    logic        rst8_n, enable8, sig8;
    logic [7:0]  high8, per8;
    logic [6:0]  pct8;
    logic        valid8, ovf8, missed8;

    duty_cycle_meter #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sig_in(sig_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .duty_pct(duty_pct),
        .valid(valid), .overflow(overflow), .missed(missed)
    );

    duty_cycle_meter #(.CNT_W(8)) dut8 (
        .clk(clk), .rst_n(rst8_n), .enable(enable8), .sig_in(sig8),
        .high_cnt(high8), .period_cnt(per8), .duty_pct(pct8),
        .valid(valid8), .overflow(ovf8), .missed(missed8)
    );

    typedef struct {
        int hi;
        int per;
        int pct;
        bit miss;
        bit ovf;
    } cap_t;

    typedef struct {
        int h;
        int l;
        int n;
        int e_hi;
        int e_per;
        int e_pct;
    } vec_t;

    int   n_vec = 0;
    int   n_err = 0;
    int   valid8_seen = 0;
    cap_t caps[$];
    cap_t exp_q[$];
    vec_t tbl[8];
    int   hs[$];
    int   ls[$];
    int   t_rise, last_rep, n_cmp;

    always @(negedge clk) begin
        if (valid === 1'b1)
            caps.push_back('{int'(high_cnt), int'(period_cnt), int'(duty_pct), missed, overflow});
        if (valid8 === 1'b1)
            valid8_seen++;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input int h, input int l);
        sig_in = 1'b1;
        tick_n(h);
        sig_in = 1'b0;
        tick_n(l);
    endtask

    task automatic start_dut();
        rst_n  = 1'b0;
        enable = 1'b0;
        sig_in = 1'b0;
        tick_n(3);
        chk("rst high_cnt", int'(high_cnt), 0);
        chk("rst period_cnt", int'(period_cnt), 0);
        chk("rst duty_pct", int'(duty_pct), 0);
        chk("rst valid", int'(valid), 0);
        chk("rst overflow", int'(overflow), 0);
        chk("rst missed", int'(missed), 0);
        rst_n  = 1'b1;
        enable = 1'b1;
        tick_n(5);
        caps.delete();
    endtask

    task automatic chk_outputs(input string tag, input int e_hi, input int e_per, input int e_pct);
        chk({tag, " high_cnt"}, int'(high_cnt), e_hi);
        chk({tag, " period_cnt"}, int'(period_cnt), e_per);
        chk({tag, " duty_pct"}, int'(duty_pct), e_pct);
    endtask

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst8_n  = 1'b0;
        enable8 = 1'b0;
        sig8    = 1'b0;
        #1;

        // steady waveforms: {high, low, reported periods, exp hi, exp per, exp pct}
        tbl[0] = '{4, 6, 4, 4, 10, 40};
        tbl[1] = '{8, 12, 3, 8, 20, 40};
        tbl[2] = '{3, 7, 3, 3, 10, 30};
        tbl[3] = '{3, 6, 3, 3, 9, 33};
        tbl[4] = '{7, 1, 4, 7, 8, 87};
        tbl[5] = '{1, 7, 4, 1, 8, 12};
        tbl[6] = '{9, 1, 3, 9, 10, 90};
        tbl[7] = '{20, 20, 2, 20, 40, 50};

        for (int v = 0; v < 8; v++) begin
            start_dut();
            repeat (tbl[v].n) pulse(tbl[v].h, tbl[v].l);
            pulse(tbl[v].h, 20);
            chk($sformatf("tbl%0d valid count", v), caps.size(), tbl[v].n);
            for (int i = 0; i < caps.size() && i < tbl[v].n; i++) begin
                chk($sformatf("tbl%0d[%0d] high_cnt", v, i), caps[i].hi, tbl[v].e_hi);
                chk($sformatf("tbl%0d[%0d] period_cnt", v, i), caps[i].per, tbl[v].e_per);
                chk($sformatf("tbl%0d[%0d] duty_pct", v, i), caps[i].pct, tbl[v].e_pct);
            end
        end

        // 5-cycle period lands inside a division: dropped, flagged until a clean report
        start_dut();
        repeat (3) pulse(4, 6);
        pulse(2, 3);
        sig_in = 1'b1;
        tick_n(4);
        sig_in = 1'b0;
        tick_n(2);
        chk("miss flag set", int'(missed), 1);
        tick_n(4);
        pulse(4, 6);
        pulse(4, 20);
        chk("miss valid count", caps.size(), 5);
        for (int i = 0; i < caps.size() && i < 5; i++) begin
            chk($sformatf("miss[%0d] high_cnt", i), caps[i].hi, 4);
            chk($sformatf("miss[%0d] period_cnt", i), caps[i].per, 10);
            chk($sformatf("miss[%0d] duty_pct", i), caps[i].pct, 40);
        end
        if (caps.size() >= 4) begin
            chk("miss held over interrupted valid", int'(caps[2].miss), 1);
            chk("miss cleared on clean valid", int'(caps[3].miss), 0);
        end
        chk("miss clear at end", int'(missed), 0);

        // reset in the middle of a division
        start_dut();
        pulse(10, 20);
        pulse(10, 20);
        sig_in = 1'b1;
        tick_n(6);
        rst_n = 1'b0;
        tick_n(2);
        chk_outputs("rst-div", 0, 0, 0);
        chk("rst-div missed", int'(missed), 0);
        rst_n  = 1'b1;
        tick_n(2);
        sig_in = 1'b0;
        tick_n(15);
        chk("rst-div valid count", caps.size(), 1);
        if (caps.size() >= 1) begin
            chk("rst-div first per", caps[0].per, 30);
            chk("rst-div first pct", caps[0].pct, 33);
        end
        chk_outputs("rst-div after", 0, 0, 0);

        // enable dropped during MEASURE
        start_dut();
        pulse(10, 20);
        sig_in = 1'b1;
        tick_n(10);
        sig_in = 1'b0;
        tick_n(10);
        enable = 1'b0;
        tick_n(2);
        chk("dis state", int'(dut.state_q), int'(IDLE));
        chk_outputs("dis held", 10, 30, 33);
        repeat (3) pulse(3, 5);
        chk("dis state later", int'(dut.state_q), int'(IDLE));
        chk_outputs("dis held later", 10, 30, 33);
        chk("dis valid count", caps.size(), 1);

        // 8-bit counters, single rise then constant low
        tick_n(3);
        rst8_n  = 1'b1;
        enable8 = 1'b1;
        tick_n(3);
        sig8 = 1'b1;
        tick_n(3);
        sig8 = 1'b0;
        tick_n(240);
        chk("ovf8 early", int'(ovf8), 0);
        chk("ovf8 early state", int'(dut8.state_q), int'(MEASURE));
        tick_n(24);
        chk("ovf8 set", int'(ovf8), 1);
        chk("ovf8 state", int'(dut8.state_q), int'(ARM));
        tick_n(50);
        chk("ovf8 sticky", int'(ovf8), 1);
        chk("ovf8 state later", int'(dut8.state_q), int'(ARM));
        chk("ovf8 no valid", valid8_seen, 0);
        chk("ovf8 high_cnt", int'(high8), 0);
        chk("ovf8 period_cnt", int'(per8), 0);
        chk("ovf8 duty_pct", int'(pct8), 0);
        chk("ovf8 missed", int'(missed8), 0);

        // random pulse train: a rise reports the preceding pulse unless it comes
        // within 7 cycles of the last reporting rise, when the division is still busy
        for (int k = 0; k < 80; k++) begin
            hs.push_back(int'($urandom_range(1, 12)));
            ls.push_back(int'($urandom_range(1, 12)));
        end
        t_rise   = 0;
        last_rep = -1000;
        for (int k = 1; k <= 80; k++) begin
            t_rise += hs[k-1] + ls[k-1];
            if (t_rise - last_rep > 7) begin
                exp_q.push_back('{hs[k-1], hs[k-1] + ls[k-1],
                                  (hs[k-1] * 100) / (hs[k-1] + ls[k-1]), 1'b0, 1'b0});
                last_rep = t_rise;
            end
        end
        start_dut();
        for (int k = 0; k < 80; k++) pulse(hs[k], ls[k]);
        pulse(1, 30);
        chk("rand valid count", caps.size(), exp_q.size());
        n_cmp = (caps.size() < exp_q.size()) ? caps.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++) begin
            chk($sformatf("rand[%0d] high_cnt", i), caps[i].hi, exp_q[i].hi);
            chk($sformatf("rand[%0d] period_cnt", i), caps[i].per, exp_q[i].per);
            chk($sformatf("rand[%0d] duty_pct", i), caps[i].pct, exp_q[i].pct);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
